forex_update_ctrl: RTL
======================

# forex_update_ctrl

Avalon-MM front end for the arbitrage engine: the host writes exchange-rate edge updates (source, destination, log-weight), which are buffered in a parametrised FIFO. On a run request, the block drains the FIFO into the graph container over a valid/ready port, then pulses the container start and waits for done. Status, a run counter and an interrupt are exposed back to the host. It sits between the HPS bridge and the Bellman-Ford container, and generalises the single-shot edge/trigger peripheral to queued updates, configurable widths and completion reporting.

## Interface
- PRED_W, 4: vertex index width (2^PRED_W currencies)
- WEIGHT_W, 32: edge weight width, ≤ 32
- FIFO_DEPTH, 8: update FIFO entries, power of two, ≥ 2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- chipselect  in  1  Avalon select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register index
- writedata  in  32  write data
- readdata  out  32  read data, registered, read latency 1
- irq  out  1  level interrupt
- upd_valid  out  1  edge update valid to container
- upd_src / upd_dst  out  PRED_W each  edge endpoints
- upd_weight  out  WEIGHT_W  edge weight
- upd_ready  in  1  container accepts update
- cont_start  out  1  one-cycle start pulse
- cont_done  in  1  one-cycle completion pulse

## Operation
- Register map; writes take effect when chipselect&write:
  - 0 EDGE (W): stages src = writedata[2*PRED_W-1:PRED_W] and dst = writedata[PRED_W-1:0].
  - 1 WEIGHT (W): pushes {staged src, staged dst, writedata[WEIGHT_W-1:0]}. If the FIFO is full, the entry is dropped and OVF (sticky) is set.
  - 2 CTRL (W): bit0 = run request; bit1 = clear DONE, OVF and irq; bit2 = irq enable (stored).
  - 3 STATUS (R): bit0 BUSY (state ≠ IDLE), bit1 DONE, bit2 OVF, bit3 PEND, bits[15:8] FIFO count.
  - 4 RUNS (R): 16-bit completed-run counter, wraps 0xFFFF→0.
  - 5–7: read 0; writes are ignored.
- FSM states: IDLE, DRAIN, START, RUN.
  - IDLE→DRAIN: when a run request arrives or PEND is set; PEND clears on the transition.
  - DRAIN: upd_valid = FIFO not empty; upd_* show the FIFO head. A pop occurs on upd_valid&upd_ready. When FIFO count is 0 at an edge, go to START.
  - START: cont_start=1 for exactly one cycle, then RUN.
  - RUN: on cont_done, set DONE, increment RUNS, go to IDLE. cont_done in any other state is ignored.
- A run request while BUSY sets PEND; a new run is started after returning to IDLE. Multiple requests collapse into one.
- WEIGHT pushes are accepted in all states; entries pushed during DRAIN are drained in the same pass.
- irq = DONE & irq_enable.
- When upd_valid=0, upd_src/upd_dst/upd_weight are driven 0.

## Timing
- All outputs at reset: readdata 0, irq 0, upd_valid 0, upd_* 0, cont_start 0. FIFO is emptied; RUNS, staged src/dst, DONE, OVF, PEND and irq enable are 0; state is IDLE.
- Reset is honoured mid-operation in any state and aborts the run; an in-flight container run is not tracked.
- Push on edge E → count is visible in STATUS from the read issued after E.
- CTRL run written at E0 with 1 entry and upd_ready=1:
  - DRAIN/upd_valid high after E0.
  - Pop at E1.
  - START (cont_start=1) after E2.
  - RUN after E3.
- Push and pop on the same edge: count is unchanged. Push when full coincident with a pop is accepted, and OVF is not set.
- CLEAR and cont_done on the same edge: DONE ends at 1.
- CTRL run and CLEAR in the same write: both apply.
- Readdata is updated on the edge after chipselect&read; otherwise it holds its value.

## Configuration
- FOREX_AUTORUN_EN defined: every accepted WEIGHT push also acts as a run request (sets PEND if BUSY). CTRL bit0 still works.
- Not defined: runs start only from CTRL bit0.

## Test plan
- Reset check: hold reset=0 mid-DRAIN with 3 entries → all outputs 0, STATUS reads 0x0000_0000 after release.
- Single run: EDGE=0x23 (PRED_W=4: src 2, dst 3), WEIGHT=0xFFFF_FF00, CTRL=1, upd_ready=1 → one beat src=2 dst=3 weight=0xFFFFFF00, cont_start 1 cycle, cont_done → STATUS DONE=1, RUNS=1, irq=0 (not enabled).
- Backpressure and overflow: 9 pushes with FIFO_DEPTH=8 → OVF=1, count=8. Run with upd_ready toggling every cycle → exactly 8 beats in push order, then cont_start.
- Pending run: CTRL=1 during RUN → PEND=1. cont_done → second DRAIN/START follows, RUNS=2.
- Interrupt: CTRL=0x4, then run to completion → irq=1. CTRL=0x2 → irq=0, DONE=0. CLEAR coincident with cont_done → DONE=1.
- Autorun (FOREX_AUTORUN_EN): WEIGHT write only → run starts without a CTRL write. Without the macro, the same stimulus leaves BUSY=0 and count=1.

Source files
------------

// File: rtl/forex_update_ctrl.sv
// Avalon-MM front end that queues edge updates, drains them to the graph container and tracks runs.
// Optional FOREX_AUTORUN_EN: every accepted WEIGHT push also acts as a run request.
`timescale 1ns/1ps
module forex_update_ctrl #(
   parameter int unsigned PRED_W     = 4,
   parameter int unsigned WEIGHT_W   = 32,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                chipselect,
   input  logic                write,
   input  logic                read,
   input  logic [2:0]          address,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic                irq,
   output logic                upd_valid,
   output logic [PRED_W-1:0]   upd_src,
   output logic [PRED_W-1:0]   upd_dst,
   output logic [WEIGHT_W-1:0] upd_weight,
   input  logic                upd_ready,
   output logic                cont_start,
   input  logic                cont_done
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 2*PRED_W + WEIGHT_W;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_START, S_RUN} state_t;

   state_t              state;
   logic [EW-1:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;
   logic [PRED_W-1:0]   src_q, dst_q;
   logic [15:0]         runs;
   logic                done, ovf, pend, irq_en;
   logic [EW-1:0]       head;

   logic wr_en, edge_wr, wgt_wr, ctrl_wr, full, pop, push_ok, push_drop, run_req, clear_req;

   assign wr_en     = chipselect & write;
   assign edge_wr   = wr_en && (address == 3'd0);
   assign wgt_wr    = wr_en && (address == 3'd1);
   assign ctrl_wr   = wr_en && (address == 3'd2);
   assign full      = (count == CW'(FIFO_DEPTH));
   assign pop       = upd_valid & upd_ready;
   // A push into a full FIFO still fits when the head leaves on the same edge.
   assign push_ok   = wgt_wr && (!full || pop);
   assign push_drop = wgt_wr && full && !pop;
   assign clear_req = ctrl_wr & writedata[1];
`ifdef FOREX_AUTORUN_EN
   assign run_req   = (ctrl_wr & writedata[0]) | push_ok;
`else
   assign run_req   = ctrl_wr & writedata[0];
`endif

   assign head       = mem[rd_ptr];
   assign upd_valid  = (state == S_DRAIN) && (count != '0);
   assign upd_src    = upd_valid ? head[EW-1 -: PRED_W] : '0;
   assign upd_dst    = upd_valid ? head[WEIGHT_W +: PRED_W] : '0;
   assign upd_weight = upd_valid ? head[WEIGHT_W-1:0] : '0;
   assign cont_start = (state == S_START);
   assign irq        = done & irq_en;

   // FIFO storage needs no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {src_q, dst_q, writedata[WEIGHT_W-1:0]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Control FSM with staging, sticky flags and run counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         src_q  <= '0;
         dst_q  <= '0;
         runs   <= '0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         pend   <= 1'b0;
         irq_en <= 1'b0;
      end else begin
         if (edge_wr) begin
            src_q <= writedata[2*PRED_W-1:PRED_W];
            dst_q <= writedata[PRED_W-1:0];
         end
         if (ctrl_wr)   irq_en <= writedata[2];
         if (clear_req) begin
            done <= 1'b0;
            ovf  <= 1'b0;
         end
         if (push_drop) ovf <= 1'b1;
         if (run_req && state != S_IDLE) pend <= 1'b1;
         case (state)
            S_IDLE: if (run_req || pend) begin
               state <= S_DRAIN;
               pend  <= 1'b0;
            end
            S_DRAIN: if (count == '0) state <= S_START;
            S_START: state <= S_RUN;
            S_RUN: if (cont_done) begin
               done  <= 1'b1;
               runs  <= runs + 16'd1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readdata <= '0;
      end else if (chipselect && read) begin
         case (address)
            3'd3:    readdata <= {16'd0, 8'(count), 4'd0, pend, ovf, done, (state != S_IDLE)};
            3'd4:    readdata <= {16'd0, runs};
            default: readdata <= '0;
         endcase
      end
   end
endmodule
